// File: rtl/sint_pb_arb_pkg.sv
// Shared types and constants for the scene-intersection to pixel-buffer arbiter.
// Pixel IDs are 19 bits, enough for one 640x480 frame.
package sint_pb_arb_pkg;

    localparam int PIX_W   = 19;
    localparam int NUM_SRC = 3;

    typedef logic [23:0]      color_t;
    typedef logic [PIX_W-1:0] pixel_id_t;

    typedef struct packed {
        pixel_id_t pixelID;
        color_t    color;
    } pixel_buffer_entry_t;

    localparam int ENTRY_W = $bits(pixel_buffer_entry_t);

    // Stream order is also the round-robin order.
    typedef enum logic [1:0] {
        SRC_TF  = 2'd0,
        SRC_SSF = 2'd1,
        SRC_SSH = 2'd2
    } src_e;

    typedef struct packed {
        pixel_id_t rayID;
    } tarb_t;

    typedef struct packed {
        pixel_id_t rayID;
    } sint_to_ss_t;

    typedef struct packed {
        pixel_id_t rayID;
    } sint_to_shader_t;

    localparam color_t DEF_HIT_COLOR    = 24'hFF_FF_FF;
    localparam color_t DEF_SHADOW_COLOR = 24'h40_40_40;
    localparam color_t DEF_MISS_COLOR   = 24'h00_00_80;

    // Stream index advanced by k positions, modulo NUM_SRC.
    function automatic src_e src_step(src_e s, logic [1:0] k);
        logic [2:0] sum = {1'b0, s} + {1'b0, k};
        logic [2:0] wrapped = (sum >= 3'd3) ? (sum - 3'd3) : sum;
        return src_e'(wrapped[1:0]);
    endfunction

endpackage

// File: rtl/sint_skid_buf.sv
// Two-entry FIFO placed in front of the arbiter on each input stream.
// Push is ignored when full and pop is ignored when empty.
module sint_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic [1:0]       count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; count marks which slots are valid, so stale data is never read out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sint_pb_arb.sv
// Round-robin arbiter merging the traversal, shadow and shader result streams
// into pixel-buffer writes, with a per-frame pixel counter and frame_done pulse.
module sint_pb_arb
    import sint_pb_arb_pkg::*;
#(
    parameter int     NUM_PIXELS   = 307200,
    parameter color_t HIT_COLOR    = DEF_HIT_COLOR,
    parameter color_t SHADOW_COLOR = DEF_SHADOW_COLOR,
    parameter color_t MISS_COLOR   = DEF_MISS_COLOR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tf_ds_valid,
    input  tarb_t               tf_ray_out,
    output logic                tf_ds_stall,
    input  logic                ssf_ds_valid,
    input  sint_to_ss_t         ssf_ray_out,
    output logic                ssf_ds_stall,
    input  logic                ssh_ds_valid,
    input  sint_to_shader_t     ssh_ray_out,
    output logic                ssh_ds_stall,
    input  logic                pb_full,
    output logic                pb_we,
    output pixel_buffer_entry_t pb_data,
    output logic                frame_done
);

    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIXELS - 1);

    logic [ENTRY_W-1:0] enq_data [NUM_SRC];
    logic [ENTRY_W-1:0] head     [NUM_SRC];
    logic [NUM_SRC-1:0] in_valid;
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] pop;

    logic             out_valid;
    logic             loadable;
    logic             gnt_valid;
    src_e             gnt;
    src_e             cand;
    src_e             rr_ptr;
    logic [PIX_W-1:0] pix_cnt;

    // Colour is fixed per stream, so conversion happens on the way into the buffers.
    assign enq_data[SRC_TF]  = {tf_ray_out.rayID,  HIT_COLOR};
    assign enq_data[SRC_SSF] = {ssf_ray_out.rayID, SHADOW_COLOR};
    assign enq_data[SRC_SSH] = {ssh_ray_out.rayID, MISS_COLOR};

    assign in_valid = {ssh_ds_valid, ssf_ds_valid, tf_ds_valid};

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_buf
        sint_skid_buf #(.WIDTH(ENTRY_W)) u_buf (
            .clk   (clk),
            .rst   (rst),
            .push  (in_valid[g] && !full[g]),
            .pop   (pop[g]),
            .din   (enq_data[g]),
            .head  (head[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    assign tf_ds_stall  = full[SRC_TF];
    assign ssf_ds_stall = full[SRC_SSF];
    assign ssh_ds_stall = full[SRC_SSH];

    assign pb_we    = out_valid && !pb_full;
    assign loadable = !out_valid || pb_we;

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = rr_ptr;
        cand      = rr_ptr;
        pop       = '0;
        if (loadable) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                cand = src_step(rr_ptr, 2'(k));
                if (!gnt_valid && !empty[cand]) begin
                    gnt_valid = 1'b1;
                    gnt       = cand;
                end
            end
            pop[gnt] = gnt_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            pb_data    <= '0;
            rr_ptr     <= SRC_TF;
            pix_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (pb_we) begin
                if (pix_cnt == LAST_PIX) begin
                    pix_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
            if (loadable) begin
                out_valid <= gnt_valid;
                if (gnt_valid) begin
                    pb_data <= head[gnt];
                    rr_ptr  <= src_step(gnt, 2'd1);
                end
            end
        end
    end

endmodule
